// File: rtl/matrix_mul_stream.sv
`default_nettype none
// ============================================================================
// Module   : matrix_mul_stream
// Purpose  : Streaming C = A x B multiplier (ROWS x INNER times INNER x COLS)
//            with LANES parallel MAC lanes. Operands stream in over in_*
//            (A row-major, then B row-major) and results stream out row-major
//            over out_*.
// Options  : MATMUL_SAT_EN - clamp every accumulate step instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_mul_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 4,
  parameter int INNER      = 8,
  parameter int COLS       = 4,
  parameter int LANES      = 2,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(INNER),
  parameter int SIGNED     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_last
);

  localparam int GROUPS = COLS / LANES;
  localparam int A_N    = ROWS * INNER;
  localparam int B_N    = INNER * COLS;
  localparam int A_AW   = (A_N > 1) ? $clog2(A_N) : 1;
  localparam int B_AW   = (B_N > 1) ? $clog2(B_N) : 1;
  localparam int CNT_W  = $clog2(((A_N > B_N) ? A_N : B_N) + 1);
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int K_W    = (INNER > 1) ? $clog2(INNER) : 1;
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int EXT_W  = (ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_MAC    = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  // Column groups must tile COLS exactly; refuse to build otherwise.
  if ((COLS % LANES) != 0) begin : g_cols_check
    $error("matrix_mul_stream: COLS must be a multiple of LANES");
  end

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [GRP_W-1:0]      grp_q, grp_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [ACC_WIDTH-1:0]  acc_q [LANES];
  logic [ACC_WIDTH-1:0]  acc_d [LANES];
  logic [ACC_WIDTH-1:0]  lane_sum [LANES];

  logic [DATA_WIDTH-1:0] a_mem_q [A_N];
  logic [DATA_WIDTH-1:0] b_mem_q [B_N];
  logic                  a_we, b_we;

  logic [DATA_WIDTH-1:0] a_op, b_op;
  logic [PROD_W-1:0]     prod;
  logic [ACC_WIDTH-1:0]  prod_ext;

  logic last_row, last_grp, last_lane;
  assign last_row  = (row_q  == ROW_W'(ROWS - 1));
  assign last_grp  = (grp_q  == GRP_W'(GROUPS - 1));
  assign last_lane = (lane_q == LANE_W'(LANES - 1));

`ifdef MATMUL_SAT_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX_S = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN_S = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic [ACC_WIDTH:0] wide;
`endif

  // Per-lane product of A[row][k] and B[k][group column], extended and added to the lane accumulator.
  always_comb begin
    a_op     = a_mem_q[A_AW'(int'(row_q) * INNER + int'(k_q))];
    b_op     = '0;
    prod     = '0;
    prod_ext = '0;
`ifdef MATMUL_SAT_EN
    wide     = '0;
`endif
    for (int l = 0; l < LANES; l++) begin
      b_op = b_mem_q[B_AW'(int'(k_q) * COLS + int'(grp_q) * LANES + l)];
      if (SIGNED != 0) begin
        prod     = PROD_W'(PROD_W'($signed(a_op)) * PROD_W'($signed(b_op)));
        prod_ext = ACC_WIDTH'(EXT_W'($signed(prod)));
      end else begin
        prod     = PROD_W'(a_op) * PROD_W'(b_op);
        prod_ext = ACC_WIDTH'(EXT_W'(prod));
      end
`ifdef MATMUL_SAT_EN
      // One extra bit exposes overflow; clamp to the representable range.
      if (SIGNED != 0) begin
        wide = {acc_q[l][ACC_WIDTH-1], acc_q[l]} + {prod_ext[ACC_WIDTH-1], prod_ext};
        if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
          lane_sum[l] = wide[ACC_WIDTH] ? ACC_MIN_S : ACC_MAX_S;
        end else begin
          lane_sum[l] = wide[ACC_WIDTH-1:0];
        end
      end else begin
        wide        = {1'b0, acc_q[l]} + {1'b0, prod_ext};
        lane_sum[l] = wide[ACC_WIDTH] ? '1 : wide[ACC_WIDTH-1:0];
      end
`else
      lane_sum[l] = acc_q[l] + prod_ext;
`endif
    end
  end

  // Job sequencing: load counters, MAC indices, drain lane pointer and accumulator updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    grp_d   = grp_q;
    k_d     = k_q;
    lane_d  = lane_q;
    a_we    = 1'b0;
    b_we    = 1'b0;
    for (int l = 0; l < LANES; l++) acc_d[l] = acc_q[l];
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_A;
          cnt_d   = '0;
        end
      end
      ST_LOAD_A: begin
        if (in_valid) begin
          a_we = 1'b1;
          if (cnt_q == CNT_W'(A_N - 1)) begin
            cnt_d   = '0;
            state_d = ST_LOAD_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_LOAD_B: begin
        if (in_valid) begin
          b_we = 1'b1;
          if (cnt_q == CNT_W'(B_N - 1)) begin
            cnt_d   = '0;
            state_d = ST_MAC;
            row_d   = '0;
            grp_d   = '0;
            k_d     = '0;
            lane_d  = '0;
            for (int l = 0; l < LANES; l++) acc_d[l] = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_MAC: begin
        for (int l = 0; l < LANES; l++) acc_d[l] = lane_sum[l];
        if (k_q == K_W'(INNER - 1)) begin
          k_d     = '0;
          lane_d  = '0;
          state_d = ST_DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (last_lane) begin
            lane_d = '0;
            if (last_row && last_grp) begin
              state_d = ST_FINISH;
            end else begin
              state_d = ST_MAC;
              for (int l = 0; l < LANES; l++) acc_d[l] = '0;
              if (last_grp) begin
                grp_d = '0;
                row_d = row_q + 1'b1;
              end else begin
                grp_d = grp_q + 1'b1;
              end
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and accumulator registers; reset returns everything to idle at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      grp_q   <= '0;
      k_q     <= '0;
      lane_q  <= '0;
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      grp_q   <= grp_d;
      k_q     <= k_d;
      lane_q  <= lane_d;
      for (int l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
    end
  end

  // Operand storage; contents survive reset and are overwritten by the next load.
  always_ff @(posedge clock) begin
    if (a_we) a_mem_q[A_AW'(cnt_q)] <= in_data;
    if (b_we) b_mem_q[B_AW'(cnt_q)] <= in_data;
  end

  assign busy      = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B) ||
                     (state_q == ST_MAC)    || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_FINISH);
  assign in_ready  = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_data  = out_valid ? acc_q[lane_q] : '0;
  assign out_last  = out_valid && last_row && last_grp && last_lane;

endmodule
`default_nettype wire
